pixel_period_classifier: RTL and testbench

//  Per-pixel frequency measurement stage. It consumes the 1-bit sample stream produced by
//  the pixel sampling logic (pixel_clock domain), resynchronises it to the system clock and

---
 rtl/pixel_period_classifier.sv | 201 ++++++++++++++++++++
 tb/tb_pixel_period_classifier.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_period_classifier.sv
// Per-pixel period measurement: resynchronises sample_data, times rise-to-rise periods, bins them into f0/f1 accumulators.
// Latency: rise seen after 2 sync + 1 delay flop, classification registered one cycle later. No backpressure; every period is handled.
// Optional hit counters f0_hits/f1_hits exist only when PIXEL_PERIOD_HIT_COUNT_EN is defined.
module pixel_period_classifier #(
    parameter int unsigned FREQUENCY0      = 5000,
    parameter int unsigned FREQUENCY1      = 10000,
    parameter int unsigned DEVIATION       = 20,
    parameter int unsigned CLOCK_FREQUENCY = 100000000
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    input  logic        sample_data,
    input  logic        enable,
    input  logic        clear,
    output logic        period_valid,
    output logic [31:0] period_value,
    output logic [31:0] f0_value,
    output logic [31:0] f1_value
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
    ,
    output logic [15:0] f0_hits,
    output logic [15:0] f1_hits
`endif
);

    localparam int unsigned P0 = CLOCK_FREQUENCY / FREQUENCY0;
    localparam int unsigned T0 = P0 * DEVIATION / 100;
    localparam int unsigned P1 = CLOCK_FREQUENCY / FREQUENCY1;
    localparam int unsigned T1 = P1 * DEVIATION / 100;

    localparam logic [31:0] P0_C = 32'(P0);
    localparam logic [31:0] T0_C = 32'(T0);
    localparam logic [31:0] P1_C = 32'(P1);
    localparam logic [31:0] T1_C = 32'(T1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;
    logic [31:0] counter_q, counter_d;
    logic        period_valid_q, period_valid_d;
    logic [31:0] period_value_q, period_value_d;
    logic [31:0] f0_value_q, f0_value_d;
    logic [31:0] f1_value_q, f1_value_d;
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
    logic [15:0] f0_hits_q, f0_hits_d;
    logic [15:0] f1_hits_q, f1_hits_d;
`endif

    logic rise;
    logic classify;
    logic in_f0;
    logic in_f1;

    function automatic logic in_range(input logic [31:0] v, input logic [31:0] p,
                                      input logic [31:0] t);
        logic [31:0] diff;
        diff = (v >= p) ? (v - p) : (p - v);
        return (diff <= t);
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

`ifdef PIXEL_PERIOD_HIT_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] a);
        return (a == 16'hFFFF) ? a : a + 16'd1;
    endfunction
`endif

    assign rise = s2_q & ~s3_q;

    // A saturated counter means "too long to know", so it is never binned.
    assign in_f0 = (counter_q != 32'hFFFF_FFFF) && in_range(counter_q, P0_C, T0_C);
    assign in_f1 = (counter_q != 32'hFFFF_FFFF) && in_range(counter_q, P1_C, T1_C);

    always_comb begin
        s1_d           = sample_data;
        s2_d           = s1_q;
        s3_d           = s2_q;
        state_d        = state_q;
        counter_d      = counter_q;
        period_valid_d = 1'b0;
        period_value_d = period_value_q;
        f0_value_d     = f0_value_q;
        f1_value_d     = f1_value_q;
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
        f0_hits_d      = f0_hits_q;
        f1_hits_d      = f1_hits_q;
`endif
        classify       = 1'b0;

        if (clear) begin
            state_d        = ST_IDLE;
            counter_d      = 32'd0;
            period_value_d = 32'd0;
            f0_value_d     = 32'd0;
            f1_value_d     = 32'd0;
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
            f0_hits_d      = 16'd0;
            f1_hits_d      = 16'd0;
`endif
        end else if (!enable) begin
            state_d   = ST_IDLE;
            counter_d = 32'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_ARMED;
                    counter_d = 32'd0;
                end
                ST_ARMED: begin
                    if (rise) begin
                        state_d   = ST_MEASURE;
                        counter_d = 32'd1;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        classify  = 1'b1;
                        counter_d = 32'd1;
                    end else if (counter_q != 32'hFFFF_FFFF) begin
                        counter_d = counter_q + 32'd1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    counter_d = 32'd0;
                end
            endcase
        end

        if (classify) begin
            period_valid_d = 1'b1;
            period_value_d = counter_q;
            // f0 takes precedence when the two tolerance windows overlap.
            if (in_f0) begin
                f0_value_d = sat_add32(f0_value_q, counter_q);
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
                f0_hits_d  = sat_inc16(f0_hits_q);
`endif
            end else if (in_f1) begin
                f1_value_d = sat_add32(f1_value_q, counter_q);
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
                f1_hits_d  = sat_inc16(f1_hits_q);
`endif
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            state_q        <= ST_IDLE;
            counter_q      <= 32'd0;
            period_valid_q <= 1'b0;
            period_value_q <= 32'd0;
            f0_value_q     <= 32'd0;
            f1_value_q     <= 32'd0;
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
            f0_hits_q      <= 16'd0;
            f1_hits_q      <= 16'd0;
`endif
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            state_q        <= state_d;
            counter_q      <= counter_d;
            period_valid_q <= period_valid_d;
            period_value_q <= period_value_d;
            f0_value_q     <= f0_value_d;
            f1_value_q     <= f1_value_d;
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
            f0_hits_q      <= f0_hits_d;
            f1_hits_q      <= f1_hits_d;
`endif
        end
    end

    assign period_valid = period_valid_q;
    assign period_value = period_value_q;
    assign f0_value     = f0_value_q;
    assign f1_value     = f1_value_q;
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
    assign f0_hits      = f0_hits_q;
    assign f1_hits      = f1_hits_q;
`endif

endmodule

// File: tb/tb_pixel_period_classifier.sv
// Directed bench for pixel_period_classifier at 1 MHz: P0=200/T0=40, P1=100/T1=20.
module tb_pixel_period_classifier;

    logic        clk;
    logic        rst_n;
    logic        sample_data;
    logic        enable;
    logic        clear;
    logic        period_valid;
    logic [31:0] period_value;
    logic [31:0] f0_value;
    logic [31:0] f1_value;
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
    logic [15:0] f0_hits;
    logic [15:0] f1_hits;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int vcnt   = 0;
    int base;

    pixel_period_classifier #(
        .FREQUENCY0     (5000),
        .FREQUENCY1     (10000),
        .DEVIATION      (20),
        .CLOCK_FREQUENCY(1000000)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .sample_data    (sample_data),
        .enable         (enable),
        .clear          (clear),
        .period_valid   (period_valid),
        .period_value   (period_value),
        .f0_value       (f0_value),
        .f1_value       (f1_value)
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
        ,
        .f0_hits        (f0_hits),
        .f1_hits        (f1_hits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && period_valid) vcnt = vcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One rising edge, then n cycles until the next call's edge.
    task automatic pulse(input int n);
        sample_data = 1'b1;
        repeat (n / 2) @(negedge clk);
        sample_data = 1'b0;
        repeat (n - n / 2) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        sample_data = 1'b0;
        enable      = 1'b0;
        clear       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(period_valid), 32'd0);
        chk("rst_period", period_value, 32'd0);
        chk("rst_f0", f0_value, 32'd0);
        chk("rst_f1", f1_value, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Five rises 200 apart: four f0 periods.
        enable = 1'b1;
        repeat (3) @(negedge clk);
        base = vcnt;
        repeat (5) pulse(200);
        repeat (10) @(negedge clk);
        chk("t1_valid_cnt", 32'(vcnt - base), 32'd4);
        chk("t1_period", period_value, 32'd200);
        chk("t1_f0", f0_value, 32'd800);
        chk("t1_f1", f1_value, 32'd0);
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
        chk("t1_f0_hits", 32'(f0_hits), 32'd4);
        chk("t1_f1_hits", 32'(f1_hits), 32'd0);
`endif

        // Three rises 100 apart: two f1 periods.
        do_clear();
        chk("clr_f0", f0_value, 32'd0);
        base = vcnt;
        repeat (3) pulse(100);
        repeat (10) @(negedge clk);
        chk("t2_valid_cnt", 32'(vcnt - base), 32'd2);
        chk("t2_f1", f1_value, 32'd200);
        chk("t2_f0", f0_value, 32'd0);

        // Window edges: 160/240 in f0, 80 in f1, 241 and 79 just outside.
        do_clear();
        base = vcnt;
        pulse(160);
        pulse(240);
        pulse(241);
        pulse(80);
        pulse(79);
        pulse(50);
        repeat (10) @(negedge clk);
        chk("t3_valid_cnt", 32'(vcnt - base), 32'd5);
        chk("t3_f0", f0_value, 32'd400);
        chk("t3_f1", f1_value, 32'd80);
        chk("t3_period", period_value, 32'd79);
`ifdef PIXEL_PERIOD_HIT_COUNT_EN
        chk("t3_f0_hits", 32'(f0_hits), 32'd2);
        chk("t3_f1_hits", 32'(f1_hits), 32'd1);
`endif

        // Enable dropped mid-period; first rise after re-enable only arms.
        do_clear();
        base = vcnt;
        repeat (3) pulse(200);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_hold_f0", f0_value, 32'd400);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        pulse(300);
        pulse(100);
        repeat (10) @(negedge clk);
        chk("t4_valid_cnt", 32'(vcnt - base), 32'd3);
        chk("t4_f0", f0_value, 32'd400);
        chk("t4_period", period_value, 32'd300);

        // clear lands on the same cycle as a detected rise.
        do_clear();
        repeat (2) pulse(200);
        chk("t5_pre_f0", f0_value, 32'd200);
        base = vcnt;
        sample_data = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t5_f0", f0_value, 32'd0);
        chk("t5_period", period_value, 32'd0);
        chk("t5_valid", 32'(period_valid), 32'd0);
        repeat (50) @(negedge clk);
        sample_data = 1'b0;
        repeat (50) @(negedge clk);
        pulse(200);
        repeat (10) @(negedge clk);
        chk("t5_valid_cnt", 32'(vcnt - base), 32'd0);
        chk("t5_f0_after", f0_value, 32'd0);

        // Accumulator saturation.
        do_clear();
        force dut.f0_value_q = 32'hFFFF_FFA0;
        repeat (2) @(negedge clk);
        release dut.f0_value_q;
        @(negedge clk);
        chk("t6_preload", f0_value, 32'hFFFF_FFA0);
        repeat (2) pulse(200);
        repeat (10) @(negedge clk);
        chk("t6_f0_sat", f0_value, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a period.
        pulse(60);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_f0", f0_value, 32'd0);
        chk("t7_rst_period", period_value, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
